// File: rtl/race_gear_pkg.sv
// ---------------------------------------------------------------------------
// race_gear_pkg
// Shared constants and types for the enemy respawn logic.
//   - Lane x positions (left / centre / right)
//   - Spawn start row and the parked "slot free" row
//   - Car height, the vertical distance two enemies need to avoid sharing a lane
//   - Controller state enumeration
//   - lane_of_idx: lane index (0=L, 1=C, 2=R) to x coordinate
// ---------------------------------------------------------------------------
package race_gear_pkg;

   localparam logic [9:0] LANE_L  = 10'd197;
   localparam logic [9:0] LANE_C  = 10'd279;
   localparam logic [9:0] LANE_R  = 10'd361;
   localparam logic [9:0] SPAWN_Y = 10'd0;
   localparam logic [9:0] END_Y   = 10'd620;
   localparam logic [9:0] CAR_H   = 10'd121;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2,
      FROZEN = 2'd3
   } state_e;

   function automatic logic [9:0] lane_of_idx(input logic [1:0] idx);
      logic [9:0] x_s;
      case (idx)
         2'd0:    x_s = LANE_L;
         2'd1:    x_s = LANE_C;
         default: x_s = LANE_R;
      endcase
      return x_s;
   endfunction

endpackage

// File: rtl/enemy_spawn_ctrl_if.sv
// ---------------------------------------------------------------------------
// enemy_spawn_ctrl_if
// Respawn handshake between the two enemy slots and the spawn controller.
//   slot_y0 / slot_y1   current row of each enemy slot (END_Y = slot free)
//   spawn_en            one-cycle spawn command, one bit per slot
//   spawn_x0 / spawn_x1 lane for each slot, valid while spawn_en is high
//   spawn_y0 / spawn_y1 start row for each slot, valid while spawn_en is high
// Modports:
//   master  enemy side, drives slot rows and receives spawn commands
//   slave   controller side, observes slot rows and issues spawn commands
// ---------------------------------------------------------------------------
interface enemy_spawn_ctrl_if;

   logic [9:0] slot_y0;
   logic [9:0] slot_y1;
   logic [1:0] spawn_en;
   logic [9:0] spawn_x0;
   logic [9:0] spawn_x1;
   logic [9:0] spawn_y0;
   logic [9:0] spawn_y1;

   modport master (
      output slot_y0, slot_y1,
      input  spawn_en, spawn_x0, spawn_x1, spawn_y0, spawn_y1
   );

   modport slave (
      input  slot_y0, slot_y1,
      output spawn_en, spawn_x0, spawn_x1, spawn_y0, spawn_y1
   );

endinterface

// File: rtl/enemy_spawn_ctrl_lane_sel.sv
// ---------------------------------------------------------------------------
// spawn_lane_sel
// Combinational lane picker for one enemy slot.
//   rnd      3 random bits, reduced mod 3 to a lane index (0=L, 1=C, 2=R)
//   other_x  last lane given to the other slot
//   other_y  current row of the other slot
//   lane_x   chosen lane x
// If the picked lane is the one the other enemy is still near the top of,
// the index is rotated by one so two cars do not stack in the same lane.
// ---------------------------------------------------------------------------
module spawn_lane_sel
   import race_gear_pkg::*;
(
   input  logic [2:0] rnd,
   input  logic [9:0] other_x,
   input  logic [9:0] other_y,
   output logic [9:0] lane_x
);

   logic [1:0] idx_s;
   logic [1:0] rot_s;
   logic [9:0] pick_s;

   // mod-3 reduction of rnd, then one avoidance rotation when blocked
   always_comb begin
      case (rnd)
         3'd0, 3'd3, 3'd6: idx_s = 2'd0;
         3'd1, 3'd4, 3'd7: idx_s = 2'd1;
         default:          idx_s = 2'd2;
      endcase
      pick_s = lane_of_idx(idx_s);
      if ((pick_s == other_x) && (other_y < CAR_H)) begin
         if (idx_s == 2'd2) begin
            rot_s = 2'd0;
         end else begin
            rot_s = idx_s + 2'd1;
         end
      end else begin
         rot_s = idx_s;
      end
      lane_x = lane_of_idx(rot_s);
   end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// ---------------------------------------------------------------------------
// enemy_spawn_ctrl
// Responder side of the enemy respawn handshake. Staggers the first two
// spawns after reset, then grants a respawn whenever a slot parks at END_Y,
// keeping at least MIN_GAP ticks between grants and alternating between the
// slots when both are waiting. Also steps the enemy clock accelerator and
// freezes everything on a collision until reset.
// Ports:
//   enemy_clk  block clock (enemy tick)
//   reset      synchronous, active-high
//   rnd        random bits for lane choice
//   collision  player hit (level)
//   spawn_bus  enemy_spawn_ctrl_if.slave: slot rows in, spawn commands out
//   accel      accelerator value for the enemy clock divider
//   frozen     high once a collision has frozen the game
// Build option:
//   SPAWN_LFSR_EN  when defined, rnd is ignored and an internal 8-bit
//                  Fibonacci LFSR (taps 8,6,5,4, seed 8'h01) supplies the
//                  random bits.
// ---------------------------------------------------------------------------
module enemy_spawn_ctrl
   import race_gear_pkg::*;
#(
   parameter int MIN_GAP      = 150,
   parameter int SECOND_DELAY = 250,
   parameter int ACCEL_PERIOD = 250,
   parameter int ACCEL_STEP   = 1000,
   parameter int ACCEL_MAX    = 100000
) (
   input  logic               enemy_clk,
   input  logic               reset,
   input  logic [2:0]         rnd,
   input  logic               collision,
   enemy_spawn_ctrl_if.slave  spawn_bus,
   output logic [24:0]        accel,
   output logic               frozen
);

   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_WARMUP = 2'(WARMUP);
   localparam logic [1:0] ST_RUN    = 2'(RUN);
   localparam logic [1:0] ST_FROZEN = 2'(FROZEN);

   logic [1:0]  state_r;
   logic [15:0] tick_r;
   logic [15:0] gap_r;
   logic        rr_r;
   logic [1:0]  spawn_en_r;
   logic [9:0]  spawn_x0_r;
   logic [9:0]  spawn_x1_r;
   logic [9:0]  spawn_y0_r;
   logic [9:0]  spawn_y1_r;
   logic [24:0] accel_r;
   logic        frozen_r;

   logic        req0_s;
   logic        req1_s;
   logic        contend_s;
   logic        grant0_s;
   logic        grant1_s;
   logic [15:0] gap_inc_s;
   logic [24:0] accel_sum_s;
   logic [24:0] accel_next_s;
   logic [9:0]  lane0_s;
   logic [9:0]  lane1_s;
   logic [2:0]  rnd_s;

`ifdef SPAWN_LFSR_EN
   logic [7:0] lfsr_r;
   logic       unused_rnd_s;

   assign unused_rnd_s = ^rnd;

   // free-running random source, advances every cycle out of reset
   always_ff @(posedge enemy_clk) begin
      if (reset) begin
         lfsr_r <= 8'h01;
      end else begin
         lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      end
   end

   assign rnd_s = lfsr_r[2:0];
`else
   assign rnd_s = rnd;
`endif

   spawn_lane_sel u_lane_sel0 (
      .rnd     (rnd_s),
      .other_x (spawn_x1_r),
      .other_y (spawn_bus.slot_y1),
      .lane_x  (lane0_s)
   );

   spawn_lane_sel u_lane_sel1 (
      .rnd     (rnd_s),
      .other_x (spawn_x0_r),
      .other_y (spawn_bus.slot_y0),
      .lane_x  (lane1_s)
   );

   // request decode, spacing gate, round-robin arbitration, accelerator step
   always_comb begin
      req0_s    = (spawn_bus.slot_y0 == END_Y);
      req1_s    = (spawn_bus.slot_y1 == END_Y);
      contend_s = req0_s & req1_s;
      // gap including the current tick, so grants land exactly MIN_GAP apart
      if (gap_r >= 16'(MIN_GAP)) begin
         gap_inc_s = 16'(MIN_GAP);
      end else begin
         gap_inc_s = gap_r + 16'd1;
      end
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (gap_inc_s >= 16'(MIN_GAP)) begin
         if (contend_s) begin
            if (rr_r == 1'b0) begin
               grant0_s = 1'b1;
            end else begin
               grant1_s = 1'b1;
            end
         end else begin
            grant0_s = req0_s;
            grant1_s = req1_s;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
      accel_sum_s = accel_r + 25'(ACCEL_STEP);
      if (accel_sum_s >= 25'(ACCEL_MAX)) begin
         accel_next_s = 25'd0;
      end else begin
         accel_next_s = accel_sum_s;
      end
   end

   // controller state, spawn command registers, counters and accelerator
   always_ff @(posedge enemy_clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         tick_r     <= 16'd0;
         gap_r      <= 16'(MIN_GAP);
         rr_r       <= 1'b0;
         spawn_en_r <= 2'b00;
         spawn_x0_r <= LANE_C;
         spawn_x1_r <= LANE_C;
         spawn_y0_r <= END_Y;
         spawn_y1_r <= END_Y;
         accel_r    <= 25'd0;
         frozen_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r    <= ST_WARMUP;
               spawn_en_r <= 2'b00;
            end
            ST_WARMUP: begin
               if (collision) begin
                  state_r    <= ST_FROZEN;
                  frozen_r   <= 1'b1;
                  spawn_en_r <= 2'b00;
               end else if (tick_r == 16'(SECOND_DELAY - 1)) begin
                  spawn_en_r <= 2'b10;
                  spawn_x1_r <= LANE_R;
                  spawn_y1_r <= SPAWN_Y;
                  gap_r      <= 16'd0;
                  tick_r     <= 16'd0;
                  state_r    <= ST_RUN;
               end else if (tick_r == 16'd0) begin
                  spawn_en_r <= 2'b01;
                  spawn_x0_r <= LANE_L;
                  spawn_y0_r <= SPAWN_Y;
                  tick_r     <= tick_r + 16'd1;
               end else begin
                  spawn_en_r <= 2'b00;
                  tick_r     <= tick_r + 16'd1;
               end
            end
            ST_RUN: begin
               if (collision) begin
                  // pending grant is dropped; counters hold from here on
                  state_r    <= ST_FROZEN;
                  frozen_r   <= 1'b1;
                  spawn_en_r <= 2'b00;
               end else begin
                  spawn_en_r <= {grant1_s, grant0_s};
                  if (grant0_s | grant1_s) begin
                     gap_r <= 16'd0;
                  end else begin
                     gap_r <= gap_inc_s;
                  end
                  if (grant0_s) begin
                     spawn_x0_r <= lane0_s;
                     spawn_y0_r <= SPAWN_Y;
                  end
                  if (grant1_s) begin
                     spawn_x1_r <= lane1_s;
                     spawn_y1_r <= SPAWN_Y;
                  end
                  // round-robin pointer moves only when both slots competed
                  if (contend_s & (grant0_s | grant1_s)) begin
                     rr_r <= ~rr_r;
                  end
                  if (tick_r == 16'(ACCEL_PERIOD - 1)) begin
                     tick_r  <= 16'd0;
                     accel_r <= accel_next_s;
                  end else begin
                     tick_r  <= tick_r + 16'd1;
                  end
               end
            end
            ST_FROZEN: begin
               spawn_en_r <= 2'b00;
               frozen_r   <= 1'b1;
            end
            default: begin
               state_r    <= ST_IDLE;
               spawn_en_r <= 2'b00;
            end
         endcase
      end
   end

   assign spawn_bus.spawn_en = spawn_en_r;
   assign spawn_bus.spawn_x0 = spawn_x0_r;
   assign spawn_bus.spawn_x1 = spawn_x1_r;
   assign spawn_bus.spawn_y0 = spawn_y0_r;
   assign spawn_bus.spawn_y1 = spawn_y1_r;
   assign accel              = accel_r;
   assign frozen             = frozen_r;

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enemy_spawn_ctrl
// Self-checking bench for enemy_spawn_ctrl (default build, rnd port used).
// A behavioural model counts edges since reset and derives the expected
// spawn commands, lanes, accelerator and freeze flag from the block's
// rules; a compare process checks every cycle, and directed literal checks
// pin the model at the interesting moments.
// ---------------------------------------------------------------------------
module tb_enemy_spawn_ctrl;

   localparam int MIN_GAP_C = 150;
   localparam int WARM_END  = 251;   // edge index of the second warm-up spawn

   logic        enemy_clk = 1'b0;
   logic        reset     = 1'b1;
   logic [2:0]  rnd       = 3'd0;
   logic        collision = 1'b0;
   logic [24:0] accel;
   logic        frozen;

   enemy_spawn_ctrl_if bus ();

   enemy_spawn_ctrl dut (
      .enemy_clk (enemy_clk),
      .reset     (reset),
      .rnd       (rnd),
      .collision (collision),
      .spawn_bus (bus),
      .accel     (accel),
      .frozen    (frozen)
   );

   always #5 enemy_clk = ~enemy_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          mvalid = 1'b0;
   int          e_m, run_m, last_m;
   bit          frz_m, rr_m;
   logic [1:0]  en_m;
   logic [9:0]  x_m [0:1];
   logic [9:0]  y_m [0:1];
   logic [24:0] acc_m;

   function automatic logic [9:0] pick_lane(input logic [2:0] r, input logic [9:0] ox,
                                            input logic [9:0] oy);
      logic [9:0] lanes [0:2];
      int idx;
      lanes[0] = 10'd197;
      lanes[1] = 10'd279;
      lanes[2] = 10'd361;
      idx = int'(r) % 3;
      if (lanes[idx] == ox && oy < 10'd121) idx = (idx + 1) % 3;
      return lanes[idx];
   endfunction

   task automatic model_step();
      bit r0, r1;
      int g;
      if (reset) begin
         mvalid = 1'b1;
         e_m = 0; run_m = 0; last_m = 0;
         frz_m = 1'b0; rr_m = 1'b0;
         en_m = 2'b00;
         x_m[0] = 10'd279; x_m[1] = 10'd279;
         y_m[0] = 10'd620; y_m[1] = 10'd620;
         acc_m = 25'd0;
      end else if (mvalid && !frz_m) begin
         e_m++;
         en_m = 2'b00;
         if (e_m >= 2 && collision) begin
            frz_m = 1'b1;
         end else if (e_m >= 2 && e_m <= WARM_END) begin
            if (e_m == 2) begin
               en_m = 2'b01; x_m[0] = 10'd197; y_m[0] = 10'd0;
            end
            if (e_m == WARM_END) begin
               en_m = 2'b10; x_m[1] = 10'd361; y_m[1] = 10'd0; last_m = e_m;
            end
         end else if (e_m > WARM_END) begin
            run_m++;
            acc_m = 25'(((run_m / 250) * 1000) % 100000);
            r0 = (bus.slot_y0 == 10'd620);
            r1 = (bus.slot_y1 == 10'd620);
            if ((e_m - last_m) >= MIN_GAP_C && (r0 || r1)) begin
               if (r0 && r1) begin
                  g = rr_m ? 1 : 0;
                  rr_m = !rr_m;
               end else begin
                  g = r0 ? 0 : 1;
               end
               x_m[g] = pick_lane(rnd, x_m[1-g], (g == 0) ? bus.slot_y1 : bus.slot_y0);
               y_m[g] = 10'd0;
               en_m[g] = 1'b1;
               last_m = e_m;
            end
         end
      end else begin
         en_m = 2'b00;
      end
   endtask

   initial forever begin
      @(posedge enemy_clk);
      model_step();
   end

   // compare DUT against the model every cycle, away from the active edge
   always @(negedge enemy_clk) begin
      if (mvalid) begin
         chk("cyc_spawn_en", 32'(bus.spawn_en), 32'(en_m));
         chk("cyc_spawn_x0", 32'(bus.spawn_x0), 32'(x_m[0]));
         chk("cyc_spawn_x1", 32'(bus.spawn_x1), 32'(x_m[1]));
         chk("cyc_spawn_y0", 32'(bus.spawn_y0), 32'(y_m[0]));
         chk("cyc_spawn_y1", 32'(bus.spawn_y1), 32'(y_m[1]));
         chk("cyc_accel",    32'(accel),        32'(acc_m));
         chk("cyc_frozen",   32'(frozen),       32'(frz_m));
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic wait_n(input int n);
      repeat (n) @(negedge enemy_clk);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_en"},     32'(bus.spawn_en), 32'd0);
      chk({tag, "_x0"},     32'(bus.spawn_x0), 32'd279);
      chk({tag, "_x1"},     32'(bus.spawn_x1), 32'd279);
      chk({tag, "_y0"},     32'(bus.spawn_y0), 32'd620);
      chk({tag, "_y1"},     32'(bus.spawn_y1), 32'd620);
      chk({tag, "_accel"},  32'(accel),        32'd0);
      chk({tag, "_frozen"}, 32'(frozen),       32'd0);
   endtask

   initial begin
      bus.slot_y0 = 10'd300;
      bus.slot_y1 = 10'd300;
      wait_n(3);
      check_reset_vals("rst0");

      // warm-up stagger
      reset = 1'b0;
      wait_n(2);                                  // edge 2: tick 1
      chk("warm_en0", 32'(bus.spawn_en), 32'd1);
      chk("warm_x0",  32'(bus.spawn_x0), 32'd197);
      chk("warm_y0",  32'(bus.spawn_y0), 32'd0);
      wait_n(249);                                // edge 251: tick 250
      chk("warm_en1", 32'(bus.spawn_en), 32'd2);
      chk("warm_x1",  32'(bus.spawn_x1), 32'd361);
      chk("warm_y1",  32'(bus.spawn_y1), 32'd0);

      // single grant, rnd=4 -> centre lane, one-cycle pulse
      wait_n(150);                                // edge 401
      bus.slot_y0 = 10'd620;
      rnd = 3'd4;
      wait_n(1);                                  // edge 402
      chk("grant_en",  32'(bus.spawn_en), 32'd1);
      chk("grant_x0",  32'(bus.spawn_x0), 32'd279);
      chk("grant_y0",  32'(bus.spawn_y0), 32'd0);
      wait_n(1);                                  // edge 403, still requesting
      chk("pulse_end", 32'(bus.spawn_en), 32'd0);

      // avoidance: rnd=2 picks right lane, slot1 sits there near the top
      bus.slot_y1 = 10'd50;
      rnd = 3'd2;
      wait_n(149);                                // edge 552
      chk("avoid_en", 32'(bus.spawn_en), 32'd1);
      chk("avoid_x0", 32'(bus.spawn_x0), 32'd197);
      bus.slot_y1 = 10'd200;
      wait_n(150);                                // edge 702
      chk("noavoid_en", 32'(bus.spawn_en), 32'd1);
      chk("noavoid_x0", 32'(bus.spawn_x0), 32'd361);

      // both slots waiting: slot0 first, slot1 exactly MIN_GAP later
      bus.slot_y1 = 10'd620;
      rnd = 3'd1;
      wait_n(150);                                // edge 852
      chk("both_first_en", 32'(bus.spawn_en), 32'd1);
      chk("both_first_x0", 32'(bus.spawn_x0), 32'd279);
      wait_n(149);                                // edge 1001
      chk("both_gap_en",   32'(bus.spawn_en), 32'd0);
      wait_n(1);                                  // edge 1002
      chk("both_second_en", 32'(bus.spawn_en), 32'd2);
      chk("both_second_x1", 32'(bus.spawn_x1), 32'd279);
      chk("accel_751",      32'(accel),        32'd3000);
      bus.slot_y0 = 10'd300;
      bus.slot_y1 = 10'd300;

      // accelerator top and wrap
      wait_n(24248);                              // edge 25250
      chk("accel_top",  32'(accel), 32'd99000);
      wait_n(1);                                  // edge 25251
      chk("accel_wrap", 32'(accel), 32'd0);
      wait_n(250);                                // edge 25501
      chk("accel_rewrap", 32'(accel), 32'd1000);

      // collision with a grant pending: freeze, no spawn, accel held
      bus.slot_y0 = 10'd620;
      collision = 1'b1;
      wait_n(1);
      chk("frz_flag",  32'(frozen),       32'd1);
      chk("frz_en",    32'(bus.spawn_en), 32'd0);
      chk("frz_accel", 32'(accel),        32'd1000);
      collision = 1'b0;
      wait_n(300);
      chk("frz_hold_flag",  32'(frozen),       32'd1);
      chk("frz_hold_en",    32'(bus.spawn_en), 32'd0);
      chk("frz_hold_accel", 32'(accel),        32'd1000);

      // reset out of FROZEN
      reset = 1'b1;
      wait_n(1);
      check_reset_vals("rst_frz");
      bus.slot_y0 = 10'd300;

      // collision during warm-up, then reset while frozen and colliding
      reset = 1'b0;
      wait_n(100);
      collision = 1'b1;
      wait_n(1);
      chk("warm_frz_flag", 32'(frozen),       32'd1);
      chk("warm_frz_en",   32'(bus.spawn_en), 32'd0);
      reset = 1'b1;
      wait_n(1);
      check_reset_vals("rst_warm");
      collision = 1'b0;
      reset = 1'b0;
      wait_n(2);
      chk("rewarm_en0", 32'(bus.spawn_en), 32'd1);
      chk("rewarm_x0",  32'(bus.spawn_x0), 32'd197);
      wait_n(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
